riscv_multicycle_ctrl: RTL and testbench
========================================

Name: riscv_multicycle_ctrl

Overview:
Main control FSM for the multicycle RV32I core. It sequences the shared datapath (PC, instruction register, ALU, the 32-bit 2:1 and 3:1 operand/result muxes, register file and unified memory) one instruction at a time. It drives every mux selector and register enable in the datapath. It also holds a retired-instruction counter and flags illegal opcodes.

Parameters:
CNT_W, 32, width of retired-instruction counter Instr_Count
OP_W, 7, opcode field width (fixed at 7 for RV32I; the parameter exists only for the package)

Ports:
Clk  input  1  core clock, rising edge
Reset  input  1  asynchronous, active-high reset
Opcode  input  7  Instr[6:0] from the instruction register
Zero  input  1  ALU zero flag
Mem_Ready  input  1  memory completes the current access this cycle
PCWrite  output  1  PC register enable
AdrSrc  output  1  memory address mux select: 0 = PC, 1 = ALUOut/Result
IRWrite  output  1  instruction register and OldPC enable
MemWrite  output  1  memory write strobe
RegWrite  output  1  register file write enable
ResultSrc  output  2  result mux select: 00 = ALUOut, 01 = Data, 10 = ALUResult
ALUSrcA  output  2  00 = PC, 01 = OldPC, 10 = RD1
ALUSrcB  output  2  00 = RD2/WriteData, 01 = ImmExt, 10 = constant 4
ALUOp  output  2  to ALU decoder: 00 = add, 01 = sub, 10 = funct-decoded
Illegal_Op  output  1  one-cycle pulse on an unsupported opcode
Instr_Count  output  CNT_W  number of instructions retired

Behaviour:
- Clock and reset: one clock (Clk). Reset is asynchronous and active-high.
- State register: a single state register, plus Instr_Count and Illegal_Op registers. All outputs other than Illegal_Op and Instr_Count decode combinationally from the state, Opcode, Zero and Mem_Ready.
- Reset: while Reset=1, and on the first edge after release:
  - state = FETCH, Instr_Count = 0, Illegal_Op = 0.
  - PCWrite, IRWrite, MemWrite and RegWrite are forced to 0.
  - Selectors take their FETCH values.
  - Reset mid-instruction aborts the instruction with no write.
- Defaults: any output not listed for a state is 0.
- States, their outputs, and their transitions:
  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite and PCUpdate equal Mem_Ready. Stay in FETCH while Mem_Ready=0; go to DECODE when it is 1.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target). Next state by Opcode:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1101111 -> JAL
    - 1100011 -> BEQ
    - any other value -> FETCH, with Illegal_Op=1 for exactly one cycle
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Opcode 0000011 -> MEMREAD; otherwise -> MEMWRITE.
  - MEMREAD: AdrSrc=1, ResultSrc=00. Hold until Mem_Ready=1, then -> MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 for every cycle in the state. Hold until Mem_Ready=1, then -> FETCH.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1 -> ALUWB.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1 -> FETCH.
- PC write: PCWrite = PCUpdate | (Branch & Zero).
- Latency (cycles, FETCH through last state, with Mem_Ready=1 throughout):
  - lw: 5
  - sw: 4
  - R-type / I-type: 4
  - jal: 4
  - beq: 3
  - Each cycle with Mem_Ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Instr_Count:
  - Increments by 1 on each edge that moves into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ.
  - An illegal-opcode return to FETCH does not count.
  - Wraps modulo 2^CNT_W.
- Opcode sampling: Opcode is sampled only in DECODE and MEMADR. The IR is stable there because IRWrite=0.
- Encoding: state encoding is free. Unreachable encodings return to FETCH on the next edge with no write enables asserted.

Decomposition:
- Shared package riscv_ctrl_pkg holds:
  - state enumeration
  - opcode constants OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ
  - encodings for ResultSrc, ALUSrcA, ALUSrcB and ALUOp
- One sub-module is natural: riscv_ctrl_outdec, a purely combinational state-to-control-word decoder. The FSM and counters stay in the top.

Test Plan:
- Reset check: assert Reset mid-MEMWRITE with Mem_Ready=0 -> MemWrite drops immediately (async); after release, state=FETCH and Instr_Count=0.
- Add instruction: Opcode=0110011, Mem_Ready=1 -> states FETCH, DECODE, EXECUTER, ALUWB. RegWrite=1 only in cycle 4 with ResultSrc=00. Instr_Count 0->1.
- Load with wait states: Opcode=0000011, Mem_Ready low 2 cycles in FETCH and 3 cycles in MEMREAD -> 10 cycles total. IRWrite/PCWrite pulse once in the Ready cycle. RegWrite with ResultSrc=01 in the last cycle.
- Branches: beq with Zero=1 -> PCWrite=1 in cycle 3 with ALUOp=01. beq with Zero=0 -> PCWrite stays 0. Both increment Instr_Count.
- Jump and illegal opcode: jal -> PCWrite in the JAL cycle, then RegWrite in ALUWB. Opcode=1111111 -> Illegal_Op pulse of 1 cycle, return to FETCH, Instr_Count unchanged.
- Counter wrap: preload via 2^CNT_W-1 retirements (or force with CNT_W=4 and 15 instructions), retire one more -> Instr_Count=0.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control FSM and its output decoder.
package riscv_ctrl_pkg;

    localparam int OPCODE_W = 7;
    localparam int STATE_W  = 4;

    localparam logic [OPCODE_W-1:0] OP_LW  = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_SW  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_R   = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_I   = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_JAL = 7'b1101111;
    localparam logic [OPCODE_W-1:0] OP_BEQ = 7'b1100011;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/riscv_ctrl_outdec.sv
// Combinational state-to-control-word decoder; zero latency, Mem_Ready gates the FETCH enables.
// PCWrite/reset gating is applied by the parent.
module riscv_ctrl_outdec
    import riscv_ctrl_pkg::*;
(
    input  logic [STATE_W-1:0] i_state,
    input  logic               i_mem_ready,
    output logic               o_pc_update,
    output logic               o_branch,
    output logic               o_adr_src,
    output logic               o_ir_write,
    output logic               o_mem_write,
    output logic               o_reg_write,
    output logic [1:0]         o_result_src,
    output logic [1:0]         o_alu_src_a,
    output logic [1:0]         o_alu_src_b,
    output logic [1:0]         o_alu_op
);

    always_comb begin
        o_pc_update  = 1'b0;
        o_branch     = 1'b0;
        o_adr_src    = 1'b0;
        o_ir_write   = 1'b0;
        o_mem_write  = 1'b0;
        o_reg_write  = 1'b0;
        o_result_src = RES_ALUOUT;
        o_alu_src_a  = SRCA_PC;
        o_alu_src_b  = SRCB_RD2;
        o_alu_op     = ALUOP_ADD;
        case (state_t'(i_state))
            S_FETCH: begin
                o_alu_src_b  = SRCB_FOUR;
                o_result_src = RES_ALURESULT;
                o_ir_write   = i_mem_ready;
                o_pc_update  = i_mem_ready;
            end
            S_DECODE: begin
                o_alu_src_a = SRCA_OLDPC;
                o_alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                o_alu_src_a = SRCA_RD1;
                o_alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                o_adr_src = 1'b1;
            end
            S_MEMWB: begin
                o_result_src = RES_DATA;
                o_reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                o_adr_src   = 1'b1;
                o_mem_write = 1'b1;
            end
            S_EXECUTER: begin
                o_alu_src_a = SRCA_RD1;
                o_alu_op    = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                o_alu_src_a = SRCA_RD1;
                o_alu_src_b = SRCB_IMM;
                o_alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                o_reg_write = 1'b1;
            end
            S_JAL: begin
                o_alu_src_a = SRCA_OLDPC;
                o_alu_src_b = SRCB_FOUR;
                o_pc_update = 1'b1;
            end
            S_BEQ: begin
                o_alu_src_a = SRCA_RD1;
                o_alu_op    = ALUOP_SUB;
                o_branch    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I core: 3-5 cycles per instruction plus memory wait states.
// Stalls in FETCH/MEMREAD/MEMWRITE while Mem_Ready=0; counts retired instructions, flags illegal opcodes.
module riscv_multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int OP_W  = 7
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [OP_W-1:0]  Opcode,
    input  logic             Zero,
    input  logic             Mem_Ready,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             IRWrite,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic             Illegal_Op,
    output logic [CNT_W-1:0] Instr_Count
);

    state_t              r_state;
    logic [CNT_W-1:0]    r_instr_count;
    logic                r_illegal_op;
    logic [OPCODE_W-1:0] w_opcode;
    logic                w_pc_update;
    logic                w_branch;
    logic                w_ir_write;
    logic                w_mem_write;
    logic                w_reg_write;

    assign w_opcode = Opcode[OPCODE_W-1:0];

    riscv_ctrl_outdec u_outdec (
        .i_state      (r_state),
        .i_mem_ready  (Mem_Ready),
        .o_pc_update  (w_pc_update),
        .o_branch     (w_branch),
        .o_adr_src    (AdrSrc),
        .o_ir_write   (w_ir_write),
        .o_mem_write  (w_mem_write),
        .o_reg_write  (w_reg_write),
        .o_result_src (ResultSrc),
        .o_alu_src_a  (ALUSrcA),
        .o_alu_src_b  (ALUSrcB),
        .o_alu_op     (ALUOp)
    );

    // Write enables are masked by Reset so an aborted instruction never commits anything.
    assign PCWrite     = (w_pc_update | (w_branch & Zero)) & ~Reset;
    assign IRWrite     = w_ir_write & ~Reset;
    assign MemWrite    = w_mem_write & ~Reset;
    assign RegWrite    = w_reg_write & ~Reset;
    assign Illegal_Op  = r_illegal_op;
    assign Instr_Count = r_instr_count;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state       <= S_FETCH;
            r_instr_count <= '0;
            r_illegal_op  <= 1'b0;
        end else begin
            r_illegal_op <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    if (Mem_Ready) r_state <= S_DECODE;
                end
                S_DECODE: begin
                    case (w_opcode)
                        OP_LW, OP_SW: r_state <= S_MEMADR;
                        OP_R:         r_state <= S_EXECUTER;
                        OP_I:         r_state <= S_EXECUTEI;
                        OP_JAL:       r_state <= S_JAL;
                        OP_BEQ:       r_state <= S_BEQ;
                        default: begin
                            r_state      <= S_FETCH;
                            r_illegal_op <= 1'b1;
                        end
                    endcase
                end
                S_MEMADR: begin
                    r_state <= (w_opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
                end
                S_MEMREAD: begin
                    if (Mem_Ready) r_state <= S_MEMWB;
                end
                S_MEMWB: begin
                    r_state       <= S_FETCH;
                    r_instr_count <= r_instr_count + CNT_W'(1);
                end
                S_MEMWRITE: begin
                    if (Mem_Ready) begin
                        r_state       <= S_FETCH;
                        r_instr_count <= r_instr_count + CNT_W'(1);
                    end
                end
                S_EXECUTER, S_EXECUTEI, S_JAL: begin
                    r_state <= S_ALUWB;
                end
                S_ALUWB, S_BEQ: begin
                    r_state       <= S_FETCH;
                    r_instr_count <= r_instr_count + CNT_W'(1);
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Directed table-driven bench for riscv_multicycle_ctrl, built with a 4-bit counter so wrap is reachable.
module tb_riscv_multicycle_ctrl;

    localparam int CW = 4;

    localparam logic [6:0] T_LW  = 7'b0000011;
    localparam logic [6:0] T_SW  = 7'b0100011;
    localparam logic [6:0] T_R   = 7'b0110011;
    localparam logic [6:0] T_I   = 7'b0010011;
    localparam logic [6:0] T_JAL = 7'b1101111;
    localparam logic [6:0] T_BEQ = 7'b1100011;
    localparam logic [6:0] T_BAD = 7'b1111111;

    // {PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp}
    localparam logic [12:0] C_F1    = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00};
    localparam logic [12:0] C_F0    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00};
    localparam logic [12:0] C_DEC   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00};
    localparam logic [12:0] C_MADR  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00};
    localparam logic [12:0] C_MRD   = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [12:0] C_MWB   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00};
    localparam logic [12:0] C_MWR   = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [12:0] C_EXR   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10};
    localparam logic [12:0] C_EXI   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b10};
    localparam logic [12:0] C_ALUWB = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [12:0] C_JAL   = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00};
    localparam logic [12:0] C_BEQ1  = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01};
    localparam logic [12:0] C_BEQ0  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01};

    typedef struct {
        logic [6:0]    op;
        logic          zero;
        logic          rdy;
        logic [12:0]   exp_cw;
        logic          exp_ill;
        logic [CW-1:0] exp_cnt;
    } vec_t;

    logic          Clk;
    logic          Reset;
    logic [6:0]    Opcode;
    logic          Zero;
    logic          Mem_Ready;
    logic          PCWrite;
    logic          AdrSrc;
    logic          IRWrite;
    logic          MemWrite;
    logic          RegWrite;
    logic [1:0]    ResultSrc;
    logic [1:0]    ALUSrcA;
    logic [1:0]    ALUSrcB;
    logic [1:0]    ALUOp;
    logic          Illegal_Op;
    logic [CW-1:0] Instr_Count;
    logic [12:0]   w_cw;

    int   n_checks;
    int   n_fail;
    vec_t vecs[$];

    riscv_multicycle_ctrl #(.CNT_W(CW), .OP_W(7)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Opcode      (Opcode),
        .Zero        (Zero),
        .Mem_Ready   (Mem_Ready),
        .PCWrite     (PCWrite),
        .AdrSrc      (AdrSrc),
        .IRWrite     (IRWrite),
        .MemWrite    (MemWrite),
        .RegWrite    (RegWrite),
        .ResultSrc   (ResultSrc),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .Illegal_Op  (Illegal_Op),
        .Instr_Count (Instr_Count)
    );

    assign w_cw = {PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp};

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [6:0] op, input logic z, input logic rdy,
                       input logic [12:0] cw, input logic ill, input int cnt);
        vec_t v;
        v.op      = op;
        v.zero    = z;
        v.rdy     = rdy;
        v.exp_cw  = cw;
        v.exp_ill = ill;
        v.exp_cnt = cnt[CW-1:0];
        vecs.push_back(v);
    endtask

    task automatic add_alu(input logic [6:0] op, input logic [12:0] ex_cw, input int cnt, input logic ill);
        add(op, 1'b0, 1'b1, C_F1, ill, cnt);
        add(op, 1'b0, 1'b1, C_DEC, 1'b0, cnt);
        add(op, 1'b0, 1'b1, ex_cw, 1'b0, cnt);
        add(op, 1'b0, 1'b1, C_ALUWB, 1'b0, cnt);
    endtask

    // Drive one cycle of inputs just after the edge, compare at the falling edge.
    task automatic apply_row(input int idx, input vec_t v);
        Opcode    = v.op;
        Zero      = v.zero;
        Mem_Ready = v.rdy;
        #4;
        check($sformatf("row%0d_ctrl", idx), 16'(w_cw), 16'(v.exp_cw));
        check($sformatf("row%0d_illegal", idx), 16'(Illegal_Op), 16'(v.exp_ill));
        check($sformatf("row%0d_count", idx), 16'(Instr_Count), 16'(v.exp_cnt));
        @(posedge Clk);
        #1;
    endtask

    initial begin
        vec_t v;
        n_checks = 0;
        n_fail   = 0;

        add_alu(T_R, C_EXR, 0, 1'b0);
        add_alu(T_I, C_EXI, 1, 1'b0);
        add(T_LW, 1'b0, 1'b0, C_F0, 1'b0, 2);
        add(T_LW, 1'b0, 1'b0, C_F0, 1'b0, 2);
        add(T_LW, 1'b0, 1'b1, C_F1, 1'b0, 2);
        add(T_LW, 1'b0, 1'b1, C_DEC, 1'b0, 2);
        add(T_LW, 1'b0, 1'b1, C_MADR, 1'b0, 2);
        add(T_LW, 1'b0, 1'b0, C_MRD, 1'b0, 2);
        add(T_LW, 1'b0, 1'b0, C_MRD, 1'b0, 2);
        add(T_LW, 1'b0, 1'b0, C_MRD, 1'b0, 2);
        add(T_LW, 1'b0, 1'b1, C_MRD, 1'b0, 2);
        add(T_LW, 1'b0, 1'b1, C_MWB, 1'b0, 2);
        add(T_SW, 1'b0, 1'b1, C_F1, 1'b0, 3);
        add(T_SW, 1'b0, 1'b1, C_DEC, 1'b0, 3);
        add(T_SW, 1'b0, 1'b1, C_MADR, 1'b0, 3);
        add(T_SW, 1'b0, 1'b0, C_MWR, 1'b0, 3);
        add(T_SW, 1'b0, 1'b1, C_MWR, 1'b0, 3);
        add(T_BEQ, 1'b1, 1'b1, C_F1, 1'b0, 4);
        add(T_BEQ, 1'b1, 1'b1, C_DEC, 1'b0, 4);
        add(T_BEQ, 1'b1, 1'b1, C_BEQ1, 1'b0, 4);
        add(T_BEQ, 1'b0, 1'b1, C_F1, 1'b0, 5);
        add(T_BEQ, 1'b0, 1'b1, C_DEC, 1'b0, 5);
        add(T_BEQ, 1'b0, 1'b1, C_BEQ0, 1'b0, 5);
        add(T_JAL, 1'b0, 1'b1, C_F1, 1'b0, 6);
        add(T_JAL, 1'b0, 1'b1, C_DEC, 1'b0, 6);
        add(T_JAL, 1'b0, 1'b1, C_JAL, 1'b0, 6);
        add(T_JAL, 1'b0, 1'b1, C_ALUWB, 1'b0, 6);
        add(T_BAD, 1'b0, 1'b1, C_F1, 1'b0, 7);
        add(T_BAD, 1'b0, 1'b1, C_DEC, 1'b0, 7);
        add_alu(T_R, C_EXR, 7, 1'b1);
        for (int k = 8; k < 16; k++) add_alu(T_R, C_EXR, k, 1'b0);
        add(T_R, 1'b0, 1'b0, C_F0, 1'b0, 0);

        Reset     = 1'b1;
        Opcode    = T_R;
        Zero      = 1'b0;
        Mem_Ready = 1'b1;
        #12;
        check("reset_ctrl", 16'(w_cw), 16'(C_F0));
        check("reset_illegal", 16'(Illegal_Op), 16'd0);
        check("reset_count", 16'(Instr_Count), 16'd0);
        Mem_Ready = 1'b0;
        Reset     = 1'b0;
        @(posedge Clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) apply_row(i, vecs[i]);

        // Retire one instruction, then abort a stalled store with an asynchronous reset.
        add_alu(T_R, C_EXR, 0, 1'b0);
        for (int i = vecs.size() - 4; i < vecs.size(); i++) apply_row(i, vecs[i]);
        v.op = T_SW; v.zero = 1'b0; v.exp_ill = 1'b0; v.exp_cnt = 4'd1; v.rdy = 1'b1;
        v.exp_cw = C_F1;   apply_row(900, v);
        v.exp_cw = C_DEC;  apply_row(901, v);
        v.exp_cw = C_MADR; apply_row(902, v);
        Mem_Ready = 1'b0;
        #2;
        check("stall_memwrite", 16'(MemWrite), 16'd1);
        Reset = 1'b1;
        #1;
        check("async_memwrite_drop", 16'(MemWrite), 16'd0);
        check("async_count_clear", 16'(Instr_Count), 16'd0);
        check("async_ctrl_fetch", 16'(w_cw), 16'(C_F0));
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        #2;
        check("post_reset_ctrl", 16'(w_cw), 16'(C_F0));
        check("post_reset_count", 16'(Instr_Count), 16'd0);
        @(posedge Clk);
        #1;
        v.op = T_R; v.rdy = 1'b1; v.exp_cnt = 4'd0;
        v.exp_cw = C_F1;    apply_row(910, v);
        v.exp_cw = C_DEC;   apply_row(911, v);
        v.exp_cw = C_EXR;   apply_row(912, v);
        v.exp_cw = C_ALUWB; apply_row(913, v);
        v.rdy = 1'b0; v.exp_cnt = 4'd1;
        v.exp_cw = C_F0;    apply_row(914, v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
